double_dabble_converter: RTL and testbench

//  Sequential binary-to-BCD converter (shift-add-3 / double dabble), one bit per clock.

---
 rtl/double_dabble_converter_if.sv | 31 +++
 rtl/double_dabble_converter.sv | 102 ++++++++++
 tb/tb_double_dabble_converter.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/double_dabble_converter_if.sv
// Handshake bundle between switch_logic and the double-dabble converter.
// The master side supplies the binary value, the slave side returns packed BCD.
interface double_dabble_converter_if #(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 5
);
  logic [BIN_WIDTH-1:0] bin_in;
  logic                 in_valid;
  logic                 in_ready;
  logic [4*DIGITS-1:0]  bcd_out;
  logic                 out_valid;
  logic                 overflow;

  modport master (
    output bin_in,
    output in_valid,
    input  in_ready,
    input  bcd_out,
    input  out_valid,
    input  overflow
  );

  modport slave (
    input  bin_in,
    input  in_valid,
    output in_ready,
    output bcd_out,
    output out_valid,
    output overflow
  );
endinterface

// File: rtl/double_dabble_converter.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Accepts a value when idle, shifts it through a BCD scratch register for
// BIN_WIDTH cycles, then publishes the packed digits with a one-cycle pulse.
// Optional build macro: OVERFLOW_SAT_EN -- on overflow the result shown is
// 9 in every display digit (higher digits zero) instead of the true BCD.
module double_dabble_converter #(
  parameter int BIN_WIDTH   = 16,
  parameter int DIGITS      = 5,
  parameter int DISP_DIGITS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  double_dabble_converter_if.slave bus
);

  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t               state;
  logic [BIN_WIDTH-1:0] shift_reg;
  logic [BIN_WIDTH-1:0] next_shift;
  logic [BCD_W-1:0]     scratch;
  logic [BCD_W-1:0]     adj_scratch;
  logic [BCD_W-1:0]     next_scratch;
  logic [BCD_W-1:0]     final_bcd;
  logic [CNT_W-1:0]     count;
  logic                 high_nonzero;

  // The converter only takes a new value while idle and out of reset.
  assign bus.in_ready = (state == IDLE) && !reset;

  // One shift-add-3 step: correct every digit >= 5, then shift the next bit in.
  always_comb begin
    adj_scratch = scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        adj_scratch[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
    // The top scratch bit is always zero here since DIGITS covers the full range.
    next_scratch = BCD_W'({adj_scratch, shift_reg[BIN_WIDTH-1]});
    next_shift   = {shift_reg[BIN_WIDTH-2:0], 1'b0};
    high_nonzero = |next_scratch[BCD_W-1:4*DISP_DIGITS];
`ifdef OVERFLOW_SAT_EN
    final_bcd = high_nonzero ? BCD_W'({DISP_DIGITS{4'h9}}) : next_scratch;
`else
    final_bcd = next_scratch;
`endif
  end

  // Control FSM plus datapath registers; results are held until the next completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      shift_reg     <= '0;
      scratch       <= '0;
      count         <= '0;
      bus.bcd_out   <= '0;
      bus.overflow  <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.out_valid <= 1'b0;
          if (bus.in_valid) begin
            shift_reg <= bus.bin_in;
            scratch   <= '0;
            count     <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          scratch   <= next_scratch;
          shift_reg <= next_shift;
          count     <= count + 1'b1;
          if (count == LAST_CNT) begin
            bus.bcd_out   <= final_bcd;
            bus.overflow  <= high_nonzero;
            bus.out_valid <= 1'b1;
            state         <= DONE;
          end
        end
        DONE: begin
          bus.out_valid <= 1'b0;
          state         <= IDLE;
        end
        default: begin
          bus.out_valid <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_double_dabble_converter.sv
// Self-checking bench for double_dabble_converter: a cycle-level queue model
// predicts handshake timing and decimal digits, directed cases pin literals,
// then randomized traffic with occasional resets runs against the model.
module tb_double_dabble_converter;

  localparam int BIN_WIDTH   = 16;
  localparam int DIGITS      = 5;
  localparam int DISP_DIGITS = 4;
  localparam int LATENCY     = BIN_WIDTH + 1;
  localparam int SPACING     = BIN_WIDTH + 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  double_dabble_converter_if #(.BIN_WIDTH(BIN_WIDTH), .DIGITS(DIGITS)) bus ();

  double_dabble_converter #(
    .BIN_WIDTH  (BIN_WIDTH),
    .DIGITS     (DIGITS),
    .DISP_DIGITS(DISP_DIGITS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int vec_count  = 0;
  int miss_count = 0;
  int cycle      = 0;
  int pulse_count = 0;

  typedef struct {
    int unsigned val;
    int          due;
  } job_t;

  job_t        jobs[$];
  int          acc_cycles[$];
  logic [19:0] exp_bcd = '0;
  logic        exp_ovf = 1'b0;
  int          ready_at = 0;

  // Decimal digits of a value, as the display should see them.
  function automatic logic [19:0] model_bcd(input int unsigned v);
    int unsigned x;
    logic [19:0] r;
    x = v;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
`ifdef OVERFLOW_SAT_EN
    if (v >= 10000) r = 20'h09999;
`endif
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vec_count++;
    if (act !== req) begin
      miss_count++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  always @(posedge clk) begin
    cycle++;
  end

  // Cycle model: compares every output each cycle, then advances on reset/accept.
  always @(negedge clk) begin
    logic exp_valid;
    logic exp_ready;
    if (cycle > 0) begin
      exp_valid = 1'b0;
      if (jobs.size() > 0 && jobs[0].due == cycle) begin
        exp_valid = 1'b1;
        exp_bcd   = model_bcd(jobs[0].val);
        exp_ovf   = (jobs[0].val >= 10000);
        void'(jobs.pop_front());
      end
      exp_ready = !reset && (cycle >= ready_at);
      if (bus.out_valid === 1'b1) pulse_count++;
      checkOutput("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_valid});
      checkOutput("in_ready",  {31'd0, bus.in_ready},  {31'd0, exp_ready});
      checkOutput("bcd_out",   {12'd0, bus.bcd_out},   {12'd0, exp_bcd});
      checkOutput("overflow",  {31'd0, bus.overflow},  {31'd0, exp_ovf});
      if (reset) begin
        jobs.delete();
        exp_bcd  = '0;
        exp_ovf  = 1'b0;
        ready_at = cycle + 1;
      end else if (bus.in_valid && exp_ready) begin
        jobs.push_back('{val: 32'(bus.bin_in), due: cycle + LATENCY});
        acc_cycles.push_back(cycle);
        ready_at = cycle + SPACING;
      end
    end
  end

  // Waits for the next out_valid pulse at a negedge, bounded in cycles.
  task automatic waitPulse(input string name, output logic seen);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    if (!seen) checkOutput({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  // One conversion with literal expectations; bin_in is scrambled after accept.
  task automatic applyStimulus(input int unsigned v, input logic [19:0] req_bcd,
                               input logic req_ovf, input string name);
    int   waited;
    int   acc_c;
    logic seen;
    @(posedge clk); #1;
    bus.bin_in   = 16'(v);
    bus.in_valid = 1'b1;
    waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 40) checkOutput({name, "_ready_timeout"}, 32'd0, 32'd1);
    acc_c = cycle;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.bin_in   = 16'($urandom);
    waitPulse(name, seen);
    if (seen) begin
      checkOutput({name, "_latency"},  32'(cycle - acc_c), 32'd17);
      checkOutput({name, "_bcd"},      {12'd0, bus.bcd_out}, {12'd0, req_bcd});
      checkOutput({name, "_overflow"}, {31'd0, bus.overflow}, {31'd0, req_ovf});
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic seen;
    int   pulses_before;
    bus.in_valid = 1'b0;
    bus.bin_in   = '0;
    reset        = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_bcd",      {12'd0, bus.bcd_out},  32'd0);
    checkOutput("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("[TB] directed conversions");
    applyStimulus(0,     20'h00000, 1'b0, "zero");
    applyStimulus(9999,  20'h09999, 1'b0, "v9999");
    applyStimulus(1234,  20'h01234, 1'b0, "v1234");
`ifdef OVERFLOW_SAT_EN
    applyStimulus(10000, 20'h09999, 1'b1, "v10000");
    applyStimulus(65535, 20'h09999, 1'b1, "v65535");
`else
    applyStimulus(10000, 20'h10000, 1'b1, "v10000");
    applyStimulus(65535, 20'h65535, 1'b1, "v65535");
`endif

    $display("[TB] held valid, input switched mid-conversion");
    @(posedge clk); #1;
    bus.bin_in   = 16'd42;
    bus.in_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    bus.bin_in = 16'd77;
    @(negedge clk);
    checkOutput("held_ready_low", {31'd0, bus.in_ready}, 32'd0);
    waitPulse("held_first", seen);
    if (seen) checkOutput("held_first_bcd", {12'd0, bus.bcd_out}, 32'h00042);
    waitPulse("held_second", seen);
    bus.in_valid = 1'b0;
    if (seen) begin
      checkOutput("held_second_bcd", {12'd0, bus.bcd_out}, 32'h00077);
      if (acc_cycles.size() >= 2)
        checkOutput("held_spacing", 32'(acc_cycles[$] - acc_cycles[$-1]), 32'd18);
      else
        checkOutput("held_accepts", 32'(acc_cycles.size()), 32'd2);
    end
    repeat (20) @(posedge clk);

    $display("[TB] reset during conversion");
    applyStimulus(1234, 20'h01234, 1'b0, "pre_abort");
    @(posedge clk); #1;
    bus.bin_in   = 16'd555;
    bus.in_valid = 1'b1;
    @(negedge clk);
    if (bus.in_ready !== 1'b1) checkOutput("abort_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    pulses_before = pulse_count;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("abort_bcd",      {12'd0, bus.bcd_out},  32'd0);
    checkOutput("abort_in_ready", {31'd0, bus.in_ready}, 32'd1);
    repeat (25) @(negedge clk);
    checkOutput("abort_no_pulse", 32'(pulse_count - pulses_before), 32'd0);
    applyStimulus(4321, 20'h04321, 1'b0, "post_abort");

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      bus.in_valid = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 5))
        0:       bus.bin_in = 16'(9998 + $urandom_range(0, 3));
        1:       bus.bin_in = 16'($urandom_range(0, 20));
        2:       bus.bin_in = 16'(65535 - $urandom_range(0, 3));
        default: bus.bin_in = 16'($urandom);
      endcase
      reset = ($urandom_range(0, 299) == 0);
    end
    @(posedge clk); #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    repeat (25) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
